// File: rtl/roadie_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : roadie_if                                                     |
// | Purpose  : Bundles the request side and the grant/status side of the    |
// |            roadie four-requester arbiter.                                |
// | Signals  : req[3:0]      per-requester request level                     |
// |            done[3:0]     per-requester early release                     |
// |            grant[3:0]    registered one-hot grant                        |
// |            active        high while any grant bit is set                 |
// |            owner[1:0]    index of current/last grant holder              |
// |            solo_cnt[7:0] cycles the current grant has been high          |
// |            timeout       one-cycle pulse on a hold-limit revocation      |
// | Modports : master (requester side), slave (arbiter side)                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface roadie_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       active;
  logic [1:0] owner;
  logic [7:0] solo_cnt;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  active,
    input  owner,
    input  solo_cnt,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output active,
    output owner,
    output solo_cnt,
    output timeout
  );
endinterface
`default_nettype wire

// File: rtl/roadie.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : roadie                                                        |
// | Purpose  : Round-robin arbiter for four requesters. A winner holds the   |
// |            grant until it releases (done or request drop) or until it    |
// |            has held it SOLO_MAX cycles, then the bus idles GAP_CYC       |
// |            cycles before the next arbitration.                           |
// | Ports    : clk   - rising-edge clock                                     |
// |            reset - synchronous active-high reset                         |
// |            bus   - roadie_if.slave (req/done in; grant, active, owner,   |
// |                    solo_cnt, timeout out; all outputs registered)        |
// | Params   : SOLO_MAX 1..255 max consecutive grant cycles per holder       |
// |            GAP_CYC  0..15  dead cycles between grants                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module roadie #(
  parameter int unsigned SOLO_MAX = 8,
  parameter int unsigned GAP_CYC  = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  roadie_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOLO = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] SOLO_LIMIT = 8'(SOLO_MAX);
  // Last value of the gap counter before returning to IDLE; unused when
  // GAP_CYC is zero because GAP is then never entered.
  localparam logic [3:0] GAP_LAST   = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);
  localparam logic       GAP_SKIP   = (GAP_CYC == 0);

  state_t     state_q,   state_d;
  logic [1:0] ptr_q,     ptr_d;
  logic [3:0] grant_q,   grant_d;
  logic       active_q,  active_d;
  logic [1:0] owner_q,   owner_d;
  logic [7:0] cnt_q,     cnt_d;
  logic       timeout_q, timeout_d;
  logic [3:0] gap_q,     gap_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       rel_vol;
  logic       rel_lim;

  // Round-robin search starting just after the last winner; the 2-bit
  // addition wraps, so the fourth candidate is ptr itself.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Voluntary release takes precedence over the hold limit, so a limit hit
  // that coincides with done/req-drop does not raise timeout.
  assign rel_vol = bus.done[owner_q] | ~bus.req[owner_q];
  assign rel_lim = (cnt_q == SOLO_LIMIT);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_d = 4'b0000;
        cnt_d   = 8'd0;
        if (win_found) begin
          state_d = ST_SOLO;
          grant_d = 4'b0001 << win_idx;
          owner_d = win_idx;
          ptr_d   = win_idx;
          cnt_d   = 8'd1;
        end
      end
      ST_SOLO: begin
        if (rel_vol || rel_lim) begin
          grant_d   = 4'b0000;
          cnt_d     = 8'd0;
          gap_d     = 4'd0;
          timeout_d = rel_lim & ~rel_vol;
          state_d   = GAP_SKIP ? ST_IDLE : ST_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        cnt_d   = 8'd0;
      end
    endcase

    active_d = (grant_d != 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd3;     // requester 0 wins the first arbitration
      grant_q   <= 4'b0000;
      active_q  <= 1'b0;
      owner_q   <= 2'd0;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
      gap_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      active_q  <= active_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.active   = active_q;
  assign bus.owner    = owner_q;
  assign bus.solo_cnt = cnt_q;
  assign bus.timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_roadie.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_roadie                                                     |
// | Purpose  : Self-checking bench for roadie. Instance a uses the default   |
// |            parameters, instance b uses SOLO_MAX=1 / GAP_CYC=0. A         |
// |            behavioural model predicts every cycle; predictions are       |
// |            queued at drive time and compared after the clock edge.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_roadie;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] req_a, done_a, req_b, done_b;

  roadie_if u_if_a ();
  roadie_if u_if_b ();

  roadie #(.SOLO_MAX(8), .GAP_CYC(2)) u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (u_if_a)
  );

  roadie #(.SOLO_MAX(1), .GAP_CYC(0)) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (u_if_b)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       inst;
    logic [3:0] grant;
    logic       active;
    logic [1:0] owner;
    logic [7:0] cnt;
    logic       to;
  } exp_t;

  exp_t sb_q[$];

  int         P_SMAX[2] = '{8, 1};
  int         P_GAP[2]  = '{2, 0};
  int         m_st[2];     // 0 idle, 1 holding, 2 dead time
  int         m_ptr[2];
  int         m_owner[2];
  int         m_cnt[2];
  int         m_gap[2];
  logic [3:0] m_grant[2];
  logic       m_to[2];

  task automatic model_step(input int i, input logic rst, input logic [3:0] req,
                            input logic [3:0] done);
    bit   vol, lim;
    int   w;
    exp_t e;
    m_to[i] = 1'b0;
    if (rst) begin
      m_st[i] = 0; m_grant[i] = 4'b0; m_owner[i] = 0;
      m_cnt[i] = 0; m_ptr[i] = 3; m_gap[i] = 0;
    end else if (m_st[i] == 0) begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && req[(m_ptr[i] + k) % 4]) w = (m_ptr[i] + k) % 4;
      if (w >= 0) begin
        m_st[i] = 1; m_grant[i] = 4'(1 << w); m_owner[i] = w; m_ptr[i] = w; m_cnt[i] = 1;
      end
    end else if (m_st[i] == 1) begin
      vol = done[m_owner[i]] || !req[m_owner[i]];
      lim = (m_cnt[i] == P_SMAX[i]);
      if (vol || lim) begin
        m_grant[i] = 4'b0; m_cnt[i] = 0; m_gap[i] = 0;
        m_to[i] = lim && !vol;
        m_st[i] = (P_GAP[i] > 0) ? 2 : 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end else begin
      m_gap[i] = m_gap[i] + 1;
      if (m_gap[i] == P_GAP[i]) m_st[i] = 0;
    end
    e.inst   = 1'(i);
    e.grant  = m_grant[i];
    e.active = (m_grant[i] != 4'b0);
    e.owner  = 2'(m_owner[i]);
    e.cnt    = 8'(m_cnt[i]);
    e.to     = m_to[i];
    sb_q.push_back(e);
  endtask

  // ---------------- per-cycle driver / scoreboard ----------------
  logic [3:0] gtr_a[$];
  logic       ttr_a[$];
  logic [3:0] gtr_b[$];
  logic       ttr_b[$];
  logic [7:0] last_cnt_a;

  task automatic step();
    exp_t       e;
    logic [3:0] g;
    logic       act, to;
    logic [1:0] own;
    logic [7:0] cnt;
    string      p;
    u_if_a.req  = req_a;  u_if_a.done = done_a;
    u_if_b.req  = req_b;  u_if_b.done = done_b;
    model_step(0, rst_a, req_a, done_a);
    model_step(1, rst_b, req_b, done_b);
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.inst == 1'b0) begin
        p = "a"; g = u_if_a.grant; act = u_if_a.active; own = u_if_a.owner;
        cnt = u_if_a.solo_cnt; to = u_if_a.timeout;
      end else begin
        p = "b"; g = u_if_b.grant; act = u_if_b.active; own = u_if_b.owner;
        cnt = u_if_b.solo_cnt; to = u_if_b.timeout;
      end
      chk({p, ".grant"},    32'(g),   32'(e.grant));
      chk({p, ".active"},   32'(act), 32'(e.active));
      chk({p, ".owner"},    32'(own), 32'(e.owner));
      chk({p, ".solo_cnt"}, 32'(cnt), 32'(e.cnt));
      chk({p, ".timeout"},  32'(to),  32'(e.to));
      chk({p, ".onehot"},   32'($countones(g) <= 1), 32'd1);
    end
    gtr_a.push_back(u_if_a.grant); ttr_a.push_back(u_if_a.timeout);
    gtr_b.push_back(u_if_b.grant); ttr_b.push_back(u_if_b.timeout);
    last_cnt_a = u_if_a.solo_cnt;
  endtask

  task automatic clear_traces();
    gtr_a.delete(); ttr_a.delete(); gtr_b.delete(); ttr_b.delete();
  endtask

  task automatic reset_a();
    rst_a = 1'b1; req_a = 4'b0; done_a = 4'b0;
    step();
    rst_a = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] exp_g[$];
    logic [3:0] order[$];
    logic [3:0] exp_order[5];
    int         n_hi, n_to;
    bit         reached;

    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 4'b0; done_a = 4'b0; req_b = 4'b0; done_b = 4'b0;
    step();
    step();
    chk("rst.grant",    32'(u_if_a.grant),    32'd0);
    chk("rst.active",   32'(u_if_a.active),   32'd0);
    chk("rst.owner",    32'(u_if_a.owner),    32'd0);
    chk("rst.solo_cnt", 32'(u_if_a.solo_cnt), 32'd0);
    chk("rst.timeout",  32'(u_if_a.timeout),  32'd0);

    // Two requesters with the hold limit; b: single requester, 1-cycle limit.
    rst_a = 1'b0; rst_b = 1'b0; req_a = 4'b0101; req_b = 4'b1000;
    clear_traces();
    for (int c = 0; c < 24; c++) step();
    for (int k = 0; k < 8; k++) exp_g.push_back(4'b0001);
    for (int k = 0; k < 3; k++) exp_g.push_back(4'b0000);
    for (int k = 0; k < 8; k++) exp_g.push_back(4'b0100);
    for (int k = 0; k < 3; k++) exp_g.push_back(4'b0000);
    exp_g.push_back(4'b0001);
    for (int k = 0; k < exp_g.size(); k++) chk("rr2.grant_seq", 32'(gtr_a[k]), 32'(exp_g[k]));
    chk("rr2.timeout_1", 32'(ttr_a[8]),  32'd1);
    chk("rr2.timeout_2", 32'(ttr_a[19]), 32'd1);
    chk("rr2.no_early_to", 32'(ttr_a[7]), 32'd0);
    for (int k = 0; k < 20; k++) begin
      chk("solo1.grant",   32'(gtr_b[k]), (k % 2 == 0) ? 32'h8 : 32'h0);
      chk("solo1.timeout", 32'(ttr_b[k]), (k % 2 == 1) ? 32'd1 : 32'd0);
    end

    // Early release by done at solo_cnt = 3.
    reset_a();
    req_a = 4'b0010;
    clear_traces();
    for (int c = 0; c < 3; c++) step();
    done_a = 4'b0010;
    step();
    done_a = 4'b0000; req_a = 4'b0000;
    for (int c = 0; c < 4; c++) step();
    n_hi = 0; n_to = 0;
    foreach (gtr_a[k]) begin
      if (gtr_a[k] != 4'b0) n_hi++;
      if (ttr_a[k]) n_to++;
    end
    chk("done3.high_cycles", 32'(n_hi), 32'd3);
    chk("done3.timeouts",    32'(n_to), 32'd0);
    chk("done3.cnt_end",     32'(last_cnt_a), 32'd0);

    // Owner 2 releases via done exactly at the limit; non-owner done ignored.
    reset_a();
    req_a = 4'b0100;
    clear_traces();
    for (int c = 0; c < 8; c++) begin
      done_a = (c == 4) ? 4'b0001 : 4'b0000;
      step();
    end
    for (int k = 0; k < 8; k++) chk("lim_done.hold", 32'(gtr_a[k]), 32'h4);
    chk("lim_done.cnt_at_limit", 32'(last_cnt_a), 32'd8);
    done_a = 4'b0100;
    step();
    chk("lim_done.grant", 32'(u_if_a.grant),   32'd0);
    chk("lim_done.to",    32'(u_if_a.timeout), 32'd0);
    done_a = 4'b0000; req_a = 4'b0000;
    step();

    // All four requesting: full rotation.
    reset_a();
    req_a = 4'b1111;
    clear_traces();
    for (int c = 0; c < 48; c++) step();
    foreach (gtr_a[k])
      if (gtr_a[k] != 4'b0 && (k == 0 || gtr_a[k-1] == 4'b0)) order.push_back(gtr_a[k]);
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("rr4.n_grants", 32'(order.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < order.size(); k++) chk("rr4.order", 32'(order[k]), 32'(exp_order[k]));

    // Reset in the middle of owner 1's hold.
    reset_a();
    req_a = 4'b0011;
    reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      step();
      if (m_owner[0] == 1 && m_cnt[0] == 5) reached = 1'b1;
    end
    chk("midrst.reached", 32'(reached), 32'd1);
    chk("midrst.cnt_before", 32'(u_if_a.solo_cnt), 32'd5);
    rst_a = 1'b1;
    step();
    chk("midrst.grant", 32'(u_if_a.grant),   32'd0);
    chk("midrst.to",    32'(u_if_a.timeout), 32'd0);
    rst_a = 1'b0;
    step();
    chk("midrst.regrant", 32'(u_if_a.grant), 32'h1);

    req_a = 4'b0000; req_b = 4'b0000;
    for (int c = 0; c < 4; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
